shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 24 ++
 rtl/shift_arbiter_shift_core.sv | 33 +++
 rtl/shift_arbiter.sv | 88 ++++++++
 tb/tb_shift_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter slice: datapath widths, shift
// operation encodings (also used by the ALU decode) and a bit-reverse helper.
package shift_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int SHAM_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } shift_op_e;

  // Mirrors a word end-for-end so a right-shift barrel can also shift left.
  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_shift_core.sv
// Combinational 5-stage logarithmic barrel shifter (16/8/4/2/1).
// Left shifts reuse the right-shift stages by mirroring the operand in and
// the result back out, so one barrel serves both directions.
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [SHAM_W-1:0] sham,
  input  shift_op_e         op,
  output logic [DATA_W-1:0] out
);

  logic              fill;
  logic [DATA_W-1:0] s;

  // Mirror for SLL, run the right-shift stages, then select the final result.
  always_comb begin
    fill = (op == OP_SRA) && a[DATA_W-1];
    s    = (op == OP_SLL) ? bit_reverse(a) : a;
    if (sham[4]) s = {{16{fill}}, s[DATA_W-1:16]};
    if (sham[3]) s = {{8{fill}},  s[DATA_W-1:8]};
    if (sham[2]) s = {{4{fill}},  s[DATA_W-1:4]};
    if (sham[1]) s = {{2{fill}},  s[DATA_W-1:2]};
    if (sham[0]) s = {{1{fill}},  s[DATA_W-1:1]};
    out = s;
    unique case (op)
      OP_SLL:  out = bit_reverse(s);
      OP_PASS: out = a;
      default: out = s;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared barrel shifter,
// with a single-entry result buffer that can drain and refill in one cycle.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [SHAM_W-1:0] req0_sham,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [SHAM_W-1:0] req1_sham,
  input  logic [1:0]        req1_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id
);

  logic              prio;
  logic              buf_free;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] sel_data;
  logic [SHAM_W-1:0] sel_sham;
  shift_op_e         sel_op;
  logic [DATA_W-1:0] shift_out;

  // Grant one valid requester whenever the buffer is empty or draining;
  // on contention the priority holder wins. Nothing is granted during reset
  // so a request seen on the reset cycle is never accepted.
  always_comb begin
    buf_free = !out_valid || out_ready;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (!reset && buf_free) begin
      grant0 = req0_valid && (!req1_valid || (prio == 1'b0));
      grant1 = req1_valid && (!req0_valid || (prio == 1'b1));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Route the granted requester's operands into the shared shifter.
  always_comb begin
    sel_data = req0_data;
    sel_sham = req0_sham;
    sel_op   = shift_op_e'(req0_op);
    if (grant1) begin
      sel_data = req1_data;
      sel_sham = req1_sham;
      sel_op   = shift_op_e'(req1_op);
    end
  end

  shift_core u_shift_core (
    .a    (sel_data),
    .sham (sel_sham),
    .op   (sel_op),
    .out  (shift_out)
  );

  // Result buffer and priority pointer: load on grant and hand priority to
  // the other requester, otherwise clear valid once the result is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      prio      <= RR_INIT;
    end else if (grant0 || grant1) begin
      out_valid <= 1'b1;
      out_data  <= shift_out;
      out_id    <= grant1;
      prio      <= !grant1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: an abstract arbiter/shift model is
// compared against the DUT every cycle, and directed vectors pin known values.
module tb_shift_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_sham;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_sham;
  logic [1:0]  req1_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;

  int check_count = 0;
  int pass_count  = 0;

  logic        model_ok = 1'b0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_data   = '0;
  logic        m_id     = 1'b0;
  int          m_prio   = 0;

  shift_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_sham  (req0_sham),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_sham  (req1_sham),
    .req1_op    (req1_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference shift behaviour expressed with language operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    case (op)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  // Which requester the rules say is served this cycle (-1 for none).
  function automatic int pick();
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    if (req0_valid && req1_valid) return m_prio;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Model update on each rising edge using the inputs held across it.
  always @(posedge clock) begin
    int g;
    g = pick();
    if (reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 1'b0;
      m_prio  = 0;
    end else if (g == 0) begin
      m_valid = 1'b1;
      m_data  = ref_shift(req0_data, req0_sham, req0_op);
      m_id    = 1'b0;
      m_prio  = 1;
    end else if (g == 1) begin
      m_valid = 1'b1;
      m_data  = ref_shift(req1_data, req1_sham, req1_op);
      m_id    = 1'b1;
      m_prio  = 0;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    model_ok = 1'b1;
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clock) begin
    int g;
    if (model_ok) begin
      g = pick();
      checkOutput("model req0_ready", 32'(req0_ready), 32'(g == 0));
      checkOutput("model req1_ready", 32'(req1_ready), 32'(g == 1));
      checkOutput("model out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        checkOutput("model out_data", out_data, m_data);
        checkOutput("model out_id", 32'(out_id), 32'(m_id));
      end
    end
  end

  task automatic applyStimulus(
    input logic rst,
    input logic v0, input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
    input logic v1, input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1,
    input logic ordy);
    reset      = rst;
    req0_valid = v0;
    req0_data  = d0;
    req0_sham  = s0;
    req0_op    = o0;
    req1_valid = v1;
    req1_data  = d1;
    req1_sham  = s1;
    req1_op    = o1;
    out_ready  = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rst, input logic ordy);
    applyStimulus(rst, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, ordy);
  endtask

  logic [31:0] tbl_a [4];
  logic [4:0]  tbl_s [4];
  logic [1:0]  tbl_o [4];
  logic [31:0] tbl_e [4];

  initial begin
    tbl_a = '{32'h7000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl_s = '{5'd3, 5'd1, 5'd16, 5'd31};
    tbl_o = '{2'b10, 2'b01, 2'b00, 2'b10};
    tbl_e = '{32'h0E00_0000, 32'h4000_0000, 32'hFFFF_0000, 32'hFFFF_FFFF};

    // Reset with a request pending: nothing is accepted, state is cleared.
    applyStimulus(1'b1, 1'b1, 32'h1, 5'd31, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
    @(negedge clock);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset out_data", out_data, 32'h0);
    checkOutput("reset out_id", 32'(out_id), 32'h0);
    checkOutput("reset req0_ready", 32'(req0_ready), 32'h0);
    next_cycle();

    // First cycle out of reset: SLL 1 by 31.
    applyStimulus(1'b0, 1'b1, 32'h0000_0001, 5'd31, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
    @(negedge clock);
    checkOutput("first grant ready0", 32'(req0_ready), 32'h1);
    next_cycle();
    idle(1'b0, 1'b0);
    @(negedge clock);
    checkOutput("sll31 valid", 32'(out_valid), 32'h1);
    checkOutput("sll31 data", out_data, 32'h8000_0000);
    checkOutput("sll31 id", 32'(out_id), 32'h0);
    next_cycle();
    idle(1'b1, 1'b1);
    next_cycle();

    // Contention with out_ready held: grants alternate 0,1,0.
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 5'd4, 2'b10, 1'b1, 32'h8000_0000, 5'd4, 2'b01, 1'b1);
    @(negedge clock);
    checkOutput("rr grant0 ready0", 32'(req0_ready), 32'h1);
    checkOutput("rr grant0 ready1", 32'(req1_ready), 32'h0);
    next_cycle();
    @(negedge clock);
    checkOutput("rr sra data", out_data, 32'hF800_0000);
    checkOutput("rr sra id", 32'(out_id), 32'h0);
    checkOutput("rr grant1 ready1", 32'(req1_ready), 32'h1);
    next_cycle();
    @(negedge clock);
    checkOutput("rr srl data", out_data, 32'h0800_0000);
    checkOutput("rr srl id", 32'(out_id), 32'h1);
    checkOutput("rr grant2 ready0", 32'(req0_ready), 32'h1);
    next_cycle();

    // Backpressure for three cycles with both requesters waiting.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hF000_0000, 5'd28, 2'b01, 1'b1, 32'h0000_00FF, 5'd8, 2'b00, 1'b0);
      @(negedge clock);
      checkOutput("stall ready0", 32'(req0_ready), 32'h0);
      checkOutput("stall ready1", 32'(req1_ready), 32'h0);
      checkOutput("stall data", out_data, 32'hF800_0000);
      checkOutput("stall valid", 32'(out_valid), 32'h1);
      next_cycle();
    end
    applyStimulus(1'b0, 1'b1, 32'hF000_0000, 5'd28, 2'b01, 1'b1, 32'h0000_00FF, 5'd8, 2'b00, 1'b1);
    @(negedge clock);
    checkOutput("release ready1", 32'(req1_ready), 32'h1);
    next_cycle();
    @(negedge clock);
    checkOutput("no bubble valid", 32'(out_valid), 32'h1);
    checkOutput("no bubble data", out_data, 32'h0000_FF00);
    checkOutput("no bubble id", 32'(out_id), 32'h1);
    next_cycle();
    idle(1'b0, 1'b0);
    @(negedge clock);
    checkOutput("srl28 data", out_data, 32'h0000_000F);
    next_cycle();
    idle(1'b0, 1'b1);
    next_cycle();
    @(negedge clock);
    checkOutput("drain clears valid", 32'(out_valid), 32'h0);
    next_cycle();

    // Zero shift on every op, plus PASS with a nonzero amount.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, (i == 4) ? 5'd7 : 5'd0, (i == 4) ? 2'b11 : 2'(i),
                    1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
      @(negedge clock);
      if (i > 0) checkOutput("identity data", out_data, 32'hDEAD_BEEF);
      next_cycle();
    end
    idle(1'b0, 1'b1);
    @(negedge clock);
    checkOutput("identity data", out_data, 32'hDEAD_BEEF);
    next_cycle();

    // Directed shift table through requester 1.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1, tbl_a[i], tbl_s[i], tbl_o[i], 1'b1);
      @(negedge clock);
      if (i > 0) checkOutput("table data", out_data, tbl_e[i-1]);
      next_cycle();
    end
    idle(1'b0, 1'b0);
    @(negedge clock);
    checkOutput("table data", out_data, tbl_e[3]);
    checkOutput("table id", 32'(out_id), 32'h1);
    next_cycle();
    idle(1'b0, 1'b1);
    next_cycle();

    // Reset while a result is buffered and requests are pending.
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 5'd0, 2'b11, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 1'b1, 32'hAAAA_0000, 5'd1, 2'b01, 1'b1, 32'h5555_0000, 5'd1, 2'b00, 1'b1);
    @(negedge clock);
    checkOutput("pre-reset valid", 32'(out_valid), 32'h1);
    checkOutput("reset-cycle ready0", 32'(req0_ready), 32'h0);
    checkOutput("reset-cycle ready1", 32'(req1_ready), 32'h0);
    next_cycle();
    idle(1'b0, 1'b1);
    @(negedge clock);
    checkOutput("post-reset valid", 32'(out_valid), 32'h0);
    next_cycle();
    @(negedge clock);
    checkOutput("no stale result", 32'(out_valid), 32'h0);
    next_cycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 5'd4, 2'b01, 1'b1, 32'h0000_0010, 5'd4, 2'b00, 1'b1);
    @(negedge clock);
    checkOutput("priority restored ready0", 32'(req0_ready), 32'h1);
    next_cycle();
    idle(1'b0, 1'b1);
    @(negedge clock);
    checkOutput("post-reset result", out_data, 32'h0000_0001);
    checkOutput("post-reset id", 32'(out_id), 32'h0);
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
